mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns EX-stage loads/stores into DCache requests,
// aligns returned load data and registers the stage result for writeback.
module mem_access (
    input  logic        clk,
    input  logic        rst,

    input  logic        flush,
    input  logic        advance,
    output logic        advance_ready,

    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic        in_excp,
    input  logic        in_load,
    input  logic        in_store,
    input  logic        in_b,
    input  logic        in_h,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_sdata,
    input  logic        in_wreg,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_alu_wdata,

    output logic        dc_req_valid,
    input  logic        dc_req_ready,
    output logic        dc_req_we,
    output logic [31:0] dc_req_addr,
    output logic [3:0]  dc_req_wstrb,
    output logic [31:0] dc_req_wdata,
    input  logic        dc_resp_valid,
    input  logic [31:0] dc_resp_rdata,

    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic        out_wreg,
    output logic [4:0]  out_waddr,
    output logic [31:0] out_wdata,
    output logic        out_excp,

    output logic        fwd_wreg,
    output logic        fwd_data_valid,
    output logic [4:0]  fwd_waddr,
    output logic [31:0] fwd_wdata
);

    // state | meaning
    // IDLE  | nothing outstanding; request driven straight from the EX inputs
    // REQ   | request presented but not yet accepted; fields held by the stall
    // WAIT  | load accepted, waiting for the response
    // DONE  | access finished; result held until the pipeline advances
    // DRAIN | flushed load still owes a response, which is discarded
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t      state;
    logic [31:0] data_reg;
    logic        mem_op;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [3:0]  store_strb;
    logic [31:0] store_data;
    logic [31:0] result;

    assign mem_op = in_valid & (in_load | in_store) & ~in_excp;

    always_comb begin
        byte_lane = dc_resp_rdata[7:0];
        case (in_addr[1:0])
            2'd0: byte_lane = dc_resp_rdata[7:0];
            2'd1: byte_lane = dc_resp_rdata[15:8];
            2'd2: byte_lane = dc_resp_rdata[23:16];
            2'd3: byte_lane = dc_resp_rdata[31:24];
            default: byte_lane = dc_resp_rdata[7:0];
        endcase
        half_lane = in_addr[1] ? dc_resp_rdata[31:16] : dc_resp_rdata[15:0];
        if (in_b)
            load_data = {{24{byte_lane[7] & ~in_unsigned}}, byte_lane};
        else if (in_h)
            load_data = {{16{half_lane[15] & ~in_unsigned}}, half_lane};
        else
            load_data = dc_resp_rdata;
    end

    always_comb begin
        if (in_b) begin
            store_strb = 4'b0001 << in_addr[1:0];
            store_data = {4{in_sdata[7:0]}};
        end else if (in_h) begin
            store_strb = in_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{in_sdata[15:0]}};
        end else begin
            store_strb = 4'b1111;
            store_data = in_sdata;
        end
    end

    assign dc_req_we    = in_store;
    assign dc_req_addr  = in_addr;
    assign dc_req_wstrb = in_store ? store_strb : 4'b0000;
    assign dc_req_wdata = store_data;

    // Flush and reset both suppress the request in the cycle they are seen.
    always_comb begin
        dc_req_valid = 1'b0;
        case (state)
            IDLE:    dc_req_valid = mem_op & ~flush & ~rst;
            REQ:     dc_req_valid = ~flush & ~rst;
            default: dc_req_valid = 1'b0;
        endcase
    end

    assign advance_ready = (state == DRAIN) ? ~mem_op : (~mem_op | (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && mem_op) begin
                        if (dc_req_ready)
                            state <= in_load ? WAIT : DONE;
                        else
                            state <= REQ;
                    end
                end
                REQ: begin
                    if (flush)
                        state <= IDLE;
                    else if (dc_req_ready)
                        state <= in_load ? WAIT : DONE;
                end
                WAIT: begin
                    // A response landing with the flush retires the access; nothing left to drain.
                    if (flush)
                        state <= dc_resp_valid ? IDLE : DRAIN;
                    else if (dc_resp_valid) begin
                        data_reg <= load_data;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (flush || advance)
                        state <= IDLE;
                end
                DRAIN: begin
                    if (dc_resp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result = in_load ? data_reg : in_alu_wdata;

    assign fwd_wreg       = in_valid & in_wreg;
    assign fwd_waddr      = in_waddr;
    assign fwd_wdata      = result;
    assign fwd_data_valid = ~in_load | (state == DONE);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_wreg  <= 1'b0;
            out_waddr <= '0;
            out_wdata <= '0;
            out_excp  <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_pc    <= in_pc;
            out_wreg  <= in_wreg;
            out_waddr <= in_waddr;
            out_wdata <= result;
            out_excp  <= in_excp;
        end
    end

endmodule
